// File: rtl/ip2_scanchain_seq_pkg.sv
// Shared types and constants for the IP2 scan-chain test sequencer.
// Build option: IP2_SCANSEQ_COMPARE_EN (see ip2_scanchain_shreg).
package ip2_scanchain_seq_pkg;

  typedef logic [2:0] state_t_sm_ip2_scanseq;

  localparam state_t_sm_ip2_scanseq IDLE_IP2_SS       = 3'd0;
  localparam state_t_sm_ip2_scanseq DELAY_IP2_SS      = 3'd1;
  localparam state_t_sm_ip2_scanseq RESET_NOT_IP2_SS  = 3'd2;
  localparam state_t_sm_ip2_scanseq SCANLOAD_1_IP2_SS = 3'd3;
  localparam state_t_sm_ip2_scanseq SCANLOAD_2_IP2_SS = 3'd4;
  localparam state_t_sm_ip2_scanseq SHIFT_IP2_SS      = 3'd5;
  localparam state_t_sm_ip2_scanseq LOOP_NEXT_IP2_SS  = 3'd6;
  localparam state_t_sm_ip2_scanseq DONE_IP2_SS       = 3'd7;

  localparam logic SCAN_REG_MODE_SHIFT_IN  = 1'b0;
  localparam logic SCAN_REG_MODE_LOAD_COMP = 1'b1;

  typedef struct packed {
    logic load;
    logic clr;
    logic shift;
    logic sample;
  } shreg_ctl_t;

endpackage

// File: rtl/ip2_scanchain_seq_if.sv
// Pad-side bundle between the sequencer and the IP2 ASIC scan pins.
interface ip2_scanchain_seq_if;
  logic o_reset_not;
  logic o_scan_in;
  logic o_scan_load;
  logic o_vin_test_trig_out;
  logic scan_out;

  modport master (
    output o_reset_not, o_scan_in, o_scan_load,
    output o_vin_test_trig_out,
    input  scan_out
  );

  modport slave (
    input  o_reset_not, o_scan_in, o_scan_load,
    input  o_vin_test_trig_out,
    output scan_out
  );
endinterface

// File: rtl/ip2_scanchain_shreg.sv
// Circular pattern register, capture register and optional comparator.
// Build option: IP2_SCANSEQ_COMPARE_EN enables mismatch counting.
module ip2_scanchain_shreg
  import ip2_scanchain_seq_pkg::*;
#(
  parameter int CHAIN_LEN = 768,
  parameter int SCNT_W = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset_not,
  input  shreg_ctl_t           ctl,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expected_in,
  input  logic                 scan_out,
  input  logic [SCNT_W-1:0]    idx,
  output logic                 pat_bit,
  output logic [CHAIN_LEN-1:0] capture_data,
  output logic [15:0]          mismatch_cnt
);

  logic [CHAIN_LEN-1:0] pat;
  logic [CHAIN_LEN-1:0] pat_rot;
  logic [CHAIN_LEN-1:0] cap_nxt;

  assign pat_bit = pat[0];

  // Loop form keeps CHAIN_LEN=1 legal (rotation degenerates to identity).
  always_comb begin
    pat_rot = pat;
    cap_nxt = capture_data;
    for (int i = 0; i < CHAIN_LEN - 1; i++) begin
      pat_rot[i] = pat[i+1];
      cap_nxt[i] = capture_data[i+1];
    end
    pat_rot[CHAIN_LEN-1] = pat[0];
    cap_nxt[CHAIN_LEN-1] = scan_out;
  end

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      pat          <= '0;
      capture_data <= '0;
    end else begin
      if (ctl.load)
        pat <= pattern_in;
      else if (ctl.shift)
        pat <= pat_rot;
      if (ctl.sample)
        capture_data <= cap_nxt;
    end
  end

`ifdef IP2_SCANSEQ_COMPARE_EN
  logic exp_bit;

  always_comb begin
    exp_bit = 1'b0;
    for (int i = 0; i < CHAIN_LEN; i++)
      if (idx == SCNT_W'(i))
        exp_bit = expected_in[i];
  end

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not)
      mismatch_cnt <= '0;
    else if (ctl.clr)
      mismatch_cnt <= '0;
    else if (ctl.sample && (scan_out != exp_bit)
             && (mismatch_cnt != 16'hFFFF))
      mismatch_cnt <= mismatch_cnt + 16'd1;
  end
`else
  logic unused_cmp;
  assign unused_cmp   = ^{expected_in, idx, ctl.clr};
  assign mismatch_cnt = '0;
`endif

endmodule

// File: rtl/ip2_scanchain_seq.sv
// IP2 scan-chain test sequencer: reset pulse, load/compare, N shift loops.
// Build option: IP2_SCANSEQ_COMPARE_EN enables on-the-fly scan_out compare.
module ip2_scanchain_seq
  import ip2_scanchain_seq_pkg::*;
#(
  parameter  int CHAIN_LEN = 768,
  parameter  int CNT_W     = 6,
  parameter  int LOOP_W    = 8,
  localparam int SCNT_W    = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset_not,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      clk_counter,
  input  logic [CNT_W-1:0]      test_delay,
  input  logic [CNT_W-1:0]      test_trig_out_phase,
  input  logic [CNT_W-1:0]      test_sample_phase,
  input  logic                  test_mask_reset_not,
  input  logic                  start_re,
  input  logic                  abort,
  input  logic [LOOP_W-1:0]     loop_count,
  input  logic [CHAIN_LEN-1:0]  pattern_in,
  input  logic [CHAIN_LEN-1:0]  expected_in,
  ip2_scanchain_seq_if.master   pad,
  output state_t_sm_ip2_scanseq sm_state,
  output logic [CHAIN_LEN-1:0]  capture_data,
  output logic                  capture_valid,
  output logic [LOOP_W-1:0]     loop_idx,
  output logic [SCNT_W-1:0]     shift_cnt,
  output logic                  busy,
  output logic                  status_done,
  output logic                  status_aborted,
  output logic [15:0]           mismatch_cnt
);

  logic rst_q, sin_q, load_q, trig_q;
  logic tick, trig_ph, smp_ph;
  logic kill, start, last_bit, pat_bit;
  shreg_ctl_t ctl;

  assign pad.o_reset_not         = rst_q;
  assign pad.o_scan_in           = sin_q;
  assign pad.o_scan_load         = load_q;
  assign pad.o_vin_test_trig_out = trig_q;

  assign tick     = clk_counter == test_delay;
  assign trig_ph  = clk_counter == test_trig_out_phase;
  assign smp_ph   = clk_counter == test_sample_phase;
  assign kill     = busy && (abort || !enable);
  assign start    = (sm_state == IDLE_IP2_SS) && start_re
                    && enable && !abort;
  assign last_bit = shift_cnt == SCNT_W'(CHAIN_LEN - 1);

  // The last SHIFT tick does not rotate, so each loop starts at pat[0].
  always_comb begin
    ctl        = '0;
    ctl.load   = start;
    ctl.clr    = start;
    ctl.shift  = !kill && tick
                 && ((sm_state == SCANLOAD_2_IP2_SS)
                 || ((sm_state == SHIFT_IP2_SS) && !last_bit));
    ctl.sample = !kill && smp_ph && (sm_state == SHIFT_IP2_SS);
  end

  ip2_scanchain_shreg #(
    .CHAIN_LEN (CHAIN_LEN),
    .SCNT_W    (SCNT_W)
  ) u_shreg (
    .clk          (clk),
    .reset_not    (reset_not),
    .ctl          (ctl),
    .pattern_in   (pattern_in),
    .expected_in  (expected_in),
    .scan_out     (pad.scan_out),
    .idx          (shift_cnt),
    .pat_bit      (pat_bit),
    .capture_data (capture_data),
    .mismatch_cnt (mismatch_cnt)
  );

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      sm_state       <= IDLE_IP2_SS;
      rst_q          <= 1'b1;
      sin_q          <= 1'b0;
      load_q         <= SCAN_REG_MODE_LOAD_COMP;
      trig_q         <= 1'b0;
      capture_valid  <= 1'b0;
      loop_idx       <= '0;
      shift_cnt      <= '0;
      busy           <= 1'b0;
      status_done    <= 1'b0;
      status_aborted <= 1'b0;
    end else if (kill) begin
      sm_state       <= IDLE_IP2_SS;
      rst_q          <= 1'b1;
      sin_q          <= 1'b0;
      load_q         <= SCAN_REG_MODE_LOAD_COMP;
      trig_q         <= 1'b0;
      capture_valid  <= 1'b0;
      busy           <= 1'b0;
      status_aborted <= 1'b1;
    end else begin
      capture_valid <= 1'b0;
      unique case (sm_state)
        IDLE_IP2_SS: if (start) begin
          busy           <= 1'b1;
          status_done    <= 1'b0;
          status_aborted <= 1'b0;
          loop_idx       <= '0;
          shift_cnt      <= '0;
          sm_state       <= DELAY_IP2_SS;
        end
        DELAY_IP2_SS: if (tick) begin
          rst_q    <= test_mask_reset_not;
          load_q   <= SCAN_REG_MODE_SHIFT_IN;
          sm_state <= RESET_NOT_IP2_SS;
        end
        RESET_NOT_IP2_SS: if (tick) begin
          rst_q    <= 1'b1;
          load_q   <= SCAN_REG_MODE_LOAD_COMP;
          sm_state <= SCANLOAD_1_IP2_SS;
        end
        SCANLOAD_1_IP2_SS: begin
          if (trig_ph) trig_q <= 1'b1;
          if (tick) sm_state <= SCANLOAD_2_IP2_SS;
        end
        SCANLOAD_2_IP2_SS: begin
          if (trig_ph) trig_q <= 1'b0;
          if (tick) begin
            load_q   <= SCAN_REG_MODE_SHIFT_IN;
            sin_q    <= pat_bit;
            sm_state <= SHIFT_IP2_SS;
          end
        end
        SHIFT_IP2_SS: if (tick) begin
          shift_cnt <= shift_cnt + SCNT_W'(1);
          if (last_bit) begin
            load_q        <= SCAN_REG_MODE_LOAD_COMP;
            capture_valid <= 1'b1;
            sm_state      <= LOOP_NEXT_IP2_SS;
          end else begin
            sin_q <= pat_bit;
          end
        end
        LOOP_NEXT_IP2_SS: begin
          loop_idx <= loop_idx + LOOP_W'(1);
          if (loop_idx == loop_count) begin
            sm_state <= DONE_IP2_SS;
          end else begin
            shift_cnt <= '0;
            sm_state  <= SCANLOAD_1_IP2_SS;
          end
        end
        DONE_IP2_SS: begin
          status_done <= 1'b1;
          busy        <= 1'b0;
          sm_state    <= IDLE_IP2_SS;
        end
        default: sm_state <= IDLE_IP2_SS;
      endcase
    end
  end

endmodule

// File: tb/tb_ip2_scanchain_seq.sv
// Self-checking bench for ip2_scanchain_seq (CHAIN_LEN=8, 16-clk bit period).
// Expected values come from a per-run model of the shift/loop/compare rules.
module tb_ip2_scanchain_seq;
  import ip2_scanchain_seq_pkg::*;

  localparam int N  = 8;
  localparam int CW = 4;
  localparam int LW = 3;
  localparam int SW = $clog2(N + 1);
  localparam int PER = 1 << CW;
  localparam int RW = 3 + 4 + N + 1 + LW + SW + 3 + 16;

`ifdef IP2_SCANSEQ_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_not = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] clk_counter = '0;
  logic [CW-1:0] test_delay = '0;
  logic [CW-1:0] test_trig_out_phase = '0;
  logic [CW-1:0] test_sample_phase = '0;
  logic          test_mask_reset_not = 1'b1;
  logic          start_re = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] loop_count = '0;
  logic [N-1:0]  pattern_in = '0;
  logic [N-1:0]  expected_in = '0;

  state_t_sm_ip2_scanseq sm_state;
  logic [N-1:0]  capture_data;
  logic          capture_valid;
  logic [LW-1:0] loop_idx;
  logic [SW-1:0] shift_cnt;
  logic          busy, status_done, status_aborted;
  logic [15:0]   mismatch_cnt;

  int so_mode = 0;
  int total = 0;
  int bad = 0;
  int cv_cnt = 0, rst_falls = 0, rst_low = 0;
  int trig_rises = 0, load_bad = 0;
  logic prev_rst = 1'b1, prev_trig = 1'b0;
  bit sin_log[$];

  ip2_scanchain_seq_if pad_if ();

  assign pad_if.scan_out = (so_mode == 0) ? pad_if.o_scan_in
                                          : (so_mode == 2);

  ip2_scanchain_seq #(
    .CHAIN_LEN (N),
    .CNT_W     (CW),
    .LOOP_W    (LW)
  ) dut (
    .clk                 (clk),
    .reset_not           (reset_not),
    .enable              (enable),
    .clk_counter         (clk_counter),
    .test_delay          (test_delay),
    .test_trig_out_phase (test_trig_out_phase),
    .test_sample_phase   (test_sample_phase),
    .test_mask_reset_not (test_mask_reset_not),
    .start_re            (start_re),
    .abort               (abort),
    .loop_count          (loop_count),
    .pattern_in          (pattern_in),
    .expected_in         (expected_in),
    .pad                 (pad_if),
    .sm_state            (sm_state),
    .capture_data        (capture_data),
    .capture_valid       (capture_valid),
    .loop_idx            (loop_idx),
    .shift_cnt           (shift_cnt),
    .busy                (busy),
    .status_done         (status_done),
    .status_aborted      (status_aborted),
    .mismatch_cnt        (mismatch_cnt)
  );

  always #5 clk = ~clk;

  // Pad monitor; also owns the free-running phase counter.
  always @(negedge clk) begin
    if (capture_valid) cv_cnt++;
    if (!pad_if.o_reset_not) rst_low++;
    if (!pad_if.o_reset_not && prev_rst) rst_falls++;
    if (pad_if.o_vin_test_trig_out && !prev_trig) trig_rises++;
    prev_rst  = pad_if.o_reset_not;
    prev_trig = pad_if.o_vin_test_trig_out;
    if (sm_state == SHIFT_IP2_SS && pad_if.o_scan_load) load_bad++;
    if ((sm_state == SCANLOAD_1_IP2_SS || sm_state == SCANLOAD_2_IP2_SS)
        && !pad_if.o_scan_load) load_bad++;
    if (sm_state == SHIFT_IP2_SS && clk_counter == test_delay)
      sin_log.push_back(pad_if.o_scan_in);
    clk_counter = clk_counter + 1'b1;
  end

  task automatic set_phases(input logic [CW-1:0] dly,
                            input logic [CW-1:0] smp);
    test_delay          = dly;
    test_trig_out_phase = dly + CW'(5);
    test_sample_phase   = smp;
  endtask

  task automatic wait_state(input state_t_sm_ip2_scanseq s,
                            input int sc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      ok = (sm_state == s) && (sc < 0 || int'(shift_cnt) == sc);
    end
  endtask

  task automatic run_seq(input logic [N-1:0] pat, input logic [LW-1:0] lc,
                         input logic mask, input int mode,
                         input logic [N-1:0] exp, input bit poke);
    int loops, cv0, rf0, rl0, tr0, lb0, q0, mm, errs;
    logic [N-1:0] seen;
    bit done;
    loops = int'(lc) + 1;
    seen  = (mode == 0) ? pat : (mode == 1) ? '0 : '1;
    mm    = CMP ? $countones(seen ^ exp) * loops : 0;
    if (mm > 65535) mm = 65535;
    @(negedge clk);
    so_mode = mode; pattern_in = pat; loop_count = lc;
    test_mask_reset_not = mask; expected_in = exp;
    cv0 = cv_cnt; rf0 = rst_falls; rl0 = rst_low;
    tr0 = trig_rises; lb0 = load_bad; q0 = sin_log.size();
    start_re = 1'b1;
    @(negedge clk);
    start_re = 1'b0;
    pattern_in = ~pat;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL busy_on_start: got %b want 1", busy);
    end
    done = 1'b0;
    for (int i = 0; i < loops * 12 * PER + 100 && !done; i++) begin
      @(negedge clk);
      start_re = poke && (i == 50);
      done = status_done;
    end
    start_re = 1'b0;
    total++;
    if (!done) begin
      bad++; $display("FAIL run_timeout: status_done never set, lc=%0d", lc);
    end
    @(negedge clk);
    total++;
    if (cv_cnt - cv0 != loops) begin
      bad++; $display("FAIL capture_valid_count: got %0d want %0d",
                      cv_cnt - cv0, loops);
    end
    total++;
    if (loop_idx !== LW'(loops)) begin
      bad++; $display("FAIL loop_idx_done: got %0d want %0d",
                      loop_idx, LW'(loops));
    end
    total++;
    if (shift_cnt !== SW'(N)) begin
      bad++; $display("FAIL shift_cnt_end: got %0d want %0d", shift_cnt, N);
    end
    total++;
    if (capture_data !== seen) begin
      bad++; $display("FAIL capture_data: got %h want %h", capture_data, seen);
    end
    errs = 0;
    if (sin_log.size() != q0 + loops * N) errs++;
    else
      for (int l = 0; l < loops; l++)
        for (int b = 0; b < N; b++)
          if (sin_log[q0 + l * N + b] != pat[b]) errs++;
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL scan_in_seq: %0d bad bits of %0d (log %0d)",
                      errs, loops * N, sin_log.size() - q0);
    end
    total++;
    if (rst_falls - rf0 != (mask ? 0 : 1) || rst_low - rl0 != (mask ? 0 : PER)) begin
      bad++; $display("FAIL reset_pulse: falls=%0d low_clks=%0d want %0d/%0d",
                      rst_falls - rf0, rst_low - rl0, mask ? 0 : 1, mask ? 0 : PER);
    end
    total++;
    if (trig_rises - tr0 != loops) begin
      bad++; $display("FAIL trig_pulses: got %0d want %0d", trig_rises - tr0, loops);
    end
    total++;
    if (load_bad != lb0) begin
      bad++; $display("FAIL scan_load_mode: %0d bad clks", load_bad - lb0);
    end
    total++;
    if (mismatch_cnt !== 16'(mm)) begin
      bad++; $display("FAIL mismatch_cnt: got %0d want %0d", mismatch_cnt, mm);
    end
    total++;
    if ({sm_state, pad_if.o_reset_not, pad_if.o_scan_load,
         pad_if.o_vin_test_trig_out, busy, status_done, status_aborted}
        !== {IDLE_IP2_SS, 6'b110010}) begin
      bad++; $display("FAIL end_status: st=%0d rn=%b ld=%b tr=%b bz=%b dn=%b ab=%b",
                      sm_state, pad_if.o_reset_not, pad_if.o_scan_load,
                      pad_if.o_vin_test_trig_out, busy, status_done, status_aborted);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    logic [RW-1:0] got, want;
    got  = {sm_state, pad_if.o_reset_not, pad_if.o_scan_in, pad_if.o_scan_load,
            pad_if.o_vin_test_trig_out, capture_data, capture_valid, loop_idx,
            shift_cnt, busy, status_done, status_aborted, mismatch_cnt};
    want = {IDLE_IP2_SS, 4'b1010, N'(0), 1'b0, LW'(0), SW'(0), 3'b000, 16'h0};
    total++;
    if (got !== want) begin
      bad++; $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic test_reset;
    reset_not = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_values");
    reset_not = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    set_phases(4'd3, 4'd10);
    run_seq(8'hA5, 3'd0, 1'b1, 0, 8'hA5, 1'b0);
  endtask

  task automatic test_loops;
    set_phases(4'd12, 4'd2);
    run_seq(8'h3C, 3'd2, 1'b0, 0, 8'h00, 1'b1);
  endtask

  task automatic test_abort;
    bit ok;
    logic [N-1:0] capx;
    set_phases(4'd6, 4'd14);
    run_seq(8'h5A, 3'd0, 1'b1, 1, 8'h00, 1'b0);
    so_mode = 2;
    start_re = 1'b1;
    @(negedge clk);
    start_re = 1'b0;
    wait_state(SHIFT_IP2_SS, 4, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL abort_reach_shift4: timeout st=%0d cnt=%0d",
                      sm_state, shift_cnt);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({sm_state, pad_if.o_scan_load, pad_if.o_reset_not, pad_if.o_scan_in,
         pad_if.o_vin_test_trig_out, busy, status_aborted, status_done}
        !== {IDLE_IP2_SS, 7'b1100010}) begin
      bad++; $display("FAIL abort_idle: st=%0d ld=%b rn=%b si=%b tr=%b bz=%b ab=%b dn=%b",
                      sm_state, pad_if.o_scan_load, pad_if.o_reset_not,
                      pad_if.o_scan_in, pad_if.o_vin_test_trig_out, busy,
                      status_aborted, status_done);
    end
    capx = N'(((1 << 4) - 1) << (N - 4));
    total++;
    if (capture_data !== capx) begin
      bad++; $display("FAIL abort_capture: got %h want %h", capture_data, capx);
    end
    start_re = 1'b1;
    @(negedge clk);
    start_re = 1'b0;
    wait_state(SCANLOAD_1_IP2_SS, -1, ok);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    total++;
    if (!ok || sm_state !== IDLE_IP2_SS || status_aborted !== 1'b1
        || busy !== 1'b0 || capture_data !== capx) begin
      bad++; $display("FAIL enable_drop: ok=%b st=%0d ab=%b bz=%b cap=%h want cap %h",
                      ok, sm_state, status_aborted, busy, capture_data, capx);
    end
    run_seq(8'hC3, 3'd1, 1'b1, 0, 8'h00, 1'b0);
  endtask

  task automatic test_sample_eq_tick;
    set_phases(4'd7, 4'd7);
    run_seq(8'h81, 3'd0, 1'b1, 2, 8'hFF, 1'b0);
  endtask

  task automatic test_compare;
    set_phases(4'd1, 4'd9);
    run_seq(8'h0F, 3'd1, 1'b1, 1, 8'hA5, 1'b0);
  endtask

  task automatic test_async_reset;
    bit ok;
    set_phases(4'd9, 4'd0);
    so_mode = 0;
    pattern_in = 8'h96;
    start_re = 1'b1;
    @(negedge clk);
    start_re = 1'b0;
    wait_state(SCANLOAD_1_IP2_SS, -1, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL async_reach_scanload1: timeout st=%0d", sm_state);
    end
    #3 reset_not = 1'b0;
    #1 check_reset_vals("async_reset_values");
    @(negedge clk);
    reset_not = 1'b1;
    run_seq(8'h96, 3'd1, 1'b0, 0, 8'h96, 1'b0);
  endtask

  task automatic test_wrap;
    set_phases(4'd0, 4'd8);
    run_seq(8'hE7, 3'd7, 1'b1, 0, 8'h18, 1'b0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      set_phases(CW'($urandom_range(0, PER - 1)),
                 CW'($urandom_range(0, PER - 1)));
      run_seq(N'($urandom), LW'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom_range(0, 2),
              N'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loops();
    test_abort();
    test_sample_eq_tick();
    test_compare();
    test_async_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
